// File: rtl/cas3_sort_ctrl.sv
// ==== cas3_sort_ctrl : descending block sorter time-sharing one 3-input compare-and-swap ====
// ==== Rev 1.0 ==============================================================================
`default_nettype none

module cas3 #(
  parameter int BITS = 10
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [BITS-1:0] c,
  output logic [BITS-1:0] a_new,
  output logic [BITS-1:0] b_new,
  output logic [BITS-1:0] c_new
);
  logic [BITS-1:0] hi1, lo1, mid2;

  // Three-comparator network; strict compares keep ties in place.
  always_comb begin
    hi1   = (b > a) ? b : a;
    lo1   = (b > a) ? a : b;
    mid2  = (c > lo1) ? c : lo1;
    c_new = (c > lo1) ? lo1 : c;
    a_new = (mid2 > hi1) ? mid2 : hi1;
    b_new = (mid2 > hi1) ? hi1 : mid2;
  end
endmodule

module cas3_sort_ctrl #(
  parameter int N    = 8,
  parameter int BITS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic [15:0]     sort_cycles
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] WIN_END  = IW'(N - 3);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   sweep_q, sweep_d;
  logic            swapped_q, swapped_d;
  logic [15:0]     sort_cycles_q, sort_cycles_d;
  logic [BITS-1:0] rf_q [N];
  logic [BITS-1:0] rf_d [N];
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;
  logic [BITS-1:0] out_data_q, out_data_d;

  logic [IW-1:0]   idx1, idx2;
  logic [BITS-1:0] a_new, b_new, c_new;
  logic            win_swap, sweep_swap;

  assign idx1 = win_q + IW'(1);
  assign idx2 = win_q + IW'(2);

  cas3 #(.BITS(BITS)) u_cas3 (
    .a     (rf_q[win_q]),
    .b     (rf_q[idx1]),
    .c     (rf_q[idx2]),
    .a_new (a_new),
    .b_new (b_new),
    .c_new (c_new)
  );

  assign win_swap   = (a_new != rf_q[win_q]) || (b_new != rf_q[idx1]) || (c_new != rf_q[idx2]);
  assign sweep_swap = swapped_q || win_swap;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    win_d         = win_q;
    sweep_d       = sweep_q;
    swapped_d     = swapped_q;
    sort_cycles_d = sort_cycles_q;
    rf_d          = rf_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          rf_d[wr_idx_q] = in_data;
          if (wr_idx_q == LAST_IDX) begin
            state_d       = S_SORT;
            wr_idx_d      = '0;
            win_d         = '0;
            sweep_d       = '0;
            swapped_d     = 1'b0;
            sort_cycles_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      S_SORT: begin
        rf_d[win_q] = a_new;
        rf_d[idx1]  = b_new;
        rf_d[idx2]  = c_new;
        if (sort_cycles_q != 16'hFFFF) sort_cycles_d = sort_cycles_q + 16'd1;
        if (win_q == WIN_END) begin
          // A clean sweep proves every overlapping window is ordered.
          if (!sweep_swap || sweep_q == WIN_END) begin
            state_d  = S_DRAIN;
            rd_idx_d = '0;
          end else begin
            win_d     = '0;
            sweep_d   = sweep_q + IW'(1);
            swapped_d = 1'b0;
          end
        end else begin
          win_d     = win_q + IW'(1);
          swapped_d = sweep_swap;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d  = S_LOAD;
            rd_idx_d = '0;
            wr_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_DRAIN);
    busy_d      = (state_d == S_SORT) || (state_d == S_DRAIN);
    out_last_d  = (state_d == S_DRAIN) && (rd_idx_d == LAST_IDX);
    out_data_d  = (state_d == S_DRAIN) ? rf_d[rd_idx_d] : out_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOAD;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      win_q         <= '0;
      sweep_q       <= '0;
      swapped_q     <= 1'b0;
      sort_cycles_q <= '0;
      for (int k = 0; k < N; k++) rf_q[k] <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      win_q         <= win_d;
      sweep_q       <= sweep_d;
      swapped_q     <= swapped_d;
      sort_cycles_q <= sort_cycles_d;
      for (int k = 0; k < N; k++) rf_q[k] <= rf_d[k];
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      out_data_q    <= out_data_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign sort_cycles = sort_cycles_q;
endmodule

`default_nettype wire

// File: tb/tb_cas3_sort_ctrl.sv
// ==== tb_cas3_sort_ctrl : scoreboard bench for the cas3 block sorter ====
// ==== Rev 1.0 ============================================================
`default_nettype none

module tb_cas3_sort_ctrl;
  localparam int N    = 8;
  localparam int BITS = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic            out_last;
  logic            busy;
  logic [15:0]     sort_cycles;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [BITS-1:0] exp_q [$];
  logic [BITS-1:0] blk [N];
  logic [15:0]     last_sc;

  cas3_sort_ctrl #(.N(N), .BITS(BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .sort_cycles (sort_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain descending bubble sort of the block being loaded.
  task automatic push_expected();
    logic [BITS-1:0] s [N];
    logic [BITS-1:0] t;
    s = blk;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (s[j] < s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    for (int i = 0; i < N; i++) exp_q.push_back(s[i]);
  endtask

  task automatic load_block();
    push_expected();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL load_in_ready word %0d: got %b want 1", i, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_sorted();
    int cyc = 0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_in_sort: got %b want 1", busy);
    end
    while (out_valid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sort_timeout: out_valid %b after %0d cycles, want 1", out_valid, cyc);
    end
    last_sc = sort_cycles;
  endtask

  task automatic drain(input bit stall);
    int              n = 0;
    int              cyc = 0;
    bit              hold_chk;
    logic [BITS-1:0] held;
    logic [BITS-1:0] exp;
    while (n < N && cyc < 200) begin
      out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      hold_chk  = 1'b0;
      if (out_valid === 1'b1 && out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        tests_run++;
        if (out_data !== exp) begin
          tests_failed++;
          $display("FAIL out_data word %0d: got %0d want %0d", n, out_data, exp);
        end
        tests_run++;
        if (out_last !== (n == N - 1)) begin
          tests_failed++;
          $display("FAIL out_last word %0d: got %b want %b", n, out_last, (n == N - 1));
        end
        if (n == N - 1) begin
          tests_run++;
          if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL in_ready_during_last: got %b want 0", in_ready);
          end
        end
        n++;
      end else if (out_valid === 1'b1) begin
        hold_chk = 1'b1;
        held     = out_data;
      end
      step();
      cyc++;
      if (hold_chk && out_valid === 1'b1) begin
        tests_run++;
        if (out_data !== held) begin
          tests_failed++;
          $display("FAIL stall_hold: got %0d want %0d", out_data, held);
        end
      end
    end
    out_ready = 1'b0;
    tests_run++;
    if (n != N) begin
      tests_failed++;
      $display("FAIL transfer_count: got %0d want %0d", n, N);
    end
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_drain: in_ready %b out_valid %b busy %b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic check_reset_state(input string tag);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_last !== 1'b0 || sort_cycles !== 16'd0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL %s: in_ready %b out_valid %b busy %b out_last %b sort_cycles %0d out_data %0d want 1 0 0 0 0 0",
               tag, in_ready, out_valid, busy, out_last, sort_cycles, out_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    check_reset_state("reset_state");
    rst = 1'b0;
    step();
    check_reset_state("idle_after_reset");
  endtask

  task automatic test_ascending();
    blk = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7};
    load_block();
    wait_sorted();
    tests_run++;
    if (!(last_sc > 16'd6 && last_sc <= 16'd36)) begin
      tests_failed++;
      $display("FAIL ascending_sort_cycles: got %0d want 7..36", last_sc);
    end
    drain(1'b0);
    tests_run++;
    if (sort_cycles !== last_sc) begin
      tests_failed++;
      $display("FAIL sort_cycles_held: got %0d want %0d", sort_cycles, last_sc);
    end
  endtask

  task automatic test_presorted();
    blk = '{10'd9, 10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2};
    load_block();
    wait_sorted();
    tests_run++;
    if (last_sc !== 16'd6) begin
      tests_failed++;
      $display("FAIL presorted_sort_cycles: got %0d want 6", last_sc);
    end
    drain(1'b0);
  endtask

  task automatic test_equal();
    for (int i = 0; i < N; i++) blk[i] = 10'd5;
    load_block();
    wait_sorted();
    tests_run++;
    if (last_sc !== 16'd6) begin
      tests_failed++;
      $display("FAIL equal_sort_cycles: got %0d want 6", last_sc);
    end
    drain(1'b0);
  endtask

  task automatic test_extremes();
    blk = '{10'd1023, 10'd0, 10'd1023, 10'd0, 10'd512, 10'd0, 10'd1, 10'd1023};
    load_block();
    wait_sorted();
    tests_run++;
    if (last_sc > 16'd36 || last_sc < 16'd6) begin
      tests_failed++;
      $display("FAIL extremes_sort_cycles: got %0d want 6..36", last_sc);
    end
    drain(1'b0);
  endtask

  task automatic test_stall_drain();
    for (int i = 0; i < N; i++) blk[i] = BITS'($urandom_range(0, 1023));
    load_block();
    wait_sorted();
    drain(1'b1);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < N; i++) blk[i] = BITS'($urandom_range(0, 15));
      load_block();
      wait_sorted();
      drain(b[0]);
    end
  endtask

  task automatic test_reset_mid_sort();
    blk = '{10'd4, 10'd9, 10'd1, 10'd7, 10'd3, 10'd8, 10'd2, 10'd6};
    load_block();
    step(); step(); step();
    tests_run++;
    if (busy !== 1'b1 || sort_cycles !== 16'd3) begin
      tests_failed++;
      $display("FAIL mid_sort_progress: busy %b sort_cycles %0d want 1 3", busy, sort_cycles);
    end
    rst = 1'b1;
    #1;
    check_reset_state("async_reset_mid_sort");
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    blk = '{10'd3, 10'd1, 10'd2, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
    load_block();
    wait_sorted();
    drain(1'b0);
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_presorted();
    test_equal();
    test_extremes();
    test_stall_drain();
    test_back_to_back();
    test_reset_mid_sort();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire
